// File: rtl/alu_swap_pipe.sv
// Registered word-permutation stage with a two-entry skid buffer.
// Modes: pass, group reverse, bit reverse, group rotate-left.
module alu_swap_pipe #(
  parameter int DATA_W  = 8,
  parameter int GROUP_W = 4,
  parameter int CNT_W   = 16,
  parameter int ROT_W   = ((DATA_W / GROUP_W) > 2)
                          ? $clog2(DATA_W / GROUP_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [ROT_W-1:0]  in_rot,
  input  logic [DATA_W-1:0] alu_data_d_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_data_d_out,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam int NGRP = DATA_W / GROUP_W;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_m;
  logic [DATA_W-1:0]   r_s;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_in_ready;
  logic [DATA_W-1:0]   w_perm;
  logic [DATA_W-1:0]   w_m_d;
  logic                w_acc;
  logic                w_fire;
  logic                w_ld_m;
  logic                w_ld_s;
  logic                w_m_sel_s;
  int                  w_rot;

  always_comb begin
    w_perm = alu_data_d_in;
    w_rot  = int'(in_rot) % NGRP;
    unique case (in_mode)
      2'd0: w_perm = alu_data_d_in;
      2'd1: begin
        for (int g = 0; g < NGRP; g++)
          w_perm[g*GROUP_W +: GROUP_W] =
            alu_data_d_in[(NGRP-1-g)*GROUP_W +: GROUP_W];
      end
      2'd2: begin
        for (int b = 0; b < DATA_W; b++)
          w_perm[b] = alu_data_d_in[DATA_W-1-b];
      end
      2'd3: begin
        for (int g = 0; g < NGRP; g++)
          w_perm[g*GROUP_W +: GROUP_W] =
            alu_data_d_in[((g+NGRP-w_rot)%NGRP)*GROUP_W +: GROUP_W];
      end
      default: w_perm = alu_data_d_in;
    endcase
  end

  assign out_valid = (r_state != ST_EMPTY);
  assign w_acc     = in_valid & r_in_ready;
  assign w_fire    = out_valid & out_ready;

  always_comb begin
    w_next    = r_state;
    w_ld_m    = 1'b0;
    w_ld_s    = 1'b0;
    w_m_sel_s = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_next = ST_ONE;
          w_ld_m = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_fire) begin
          w_ld_m = 1'b1;
        end else if (w_acc) begin
          w_next = ST_FULL;
          w_ld_s = 1'b1;
        end else if (w_fire) begin
          w_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_fire) begin
          w_next    = ST_ONE;
          w_ld_m    = 1'b1;
          w_m_sel_s = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  assign w_m_d = w_m_sel_s ? r_s : w_perm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_m        <= '0;
      r_s        <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != ST_FULL);
      if (w_ld_m) r_m <= w_m_d;
      if (w_ld_s) r_s <= w_perm;
      if (cnt_clr)     r_cnt <= '0;
      else if (w_fire) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready       = r_in_ready;
  assign alu_data_d_out = r_m;
  assign xfer_count     = r_cnt;

endmodule

// File: doc/alu_swap_pipe.md
Name: alu_swap_pipe

Overview:
Parametrised, registered data-permutation stage for the ALU datapath. Reorders an input word in one of four selectable ways: pass-through, group reverse (nibble swap at default sizes), bit reverse, or group rotate. Sits between the ALU operand source and its consumer. Uses valid/ready handshakes on both sides, a 2-entry skid buffer for full throughput with a registered in_ready, and a transfer counter.

Parameters:
DATA_W, 8, word width; must be a multiple of GROUP_W and >= 2*GROUP_W
GROUP_W, 4, width of one permutation group
CNT_W, 16, width of the transfer counter
(derived) NGRP = DATA_W/GROUP_W; ROT_W = max(1, clog2(NGRP))

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input word present
in_ready  out  1  block can accept a word this cycle
in_mode  in  2  0 pass, 1 group reverse, 2 bit reverse, 3 group rotate-left
in_rot  in  ROT_W  rotate amount in groups; used only in mode 3
alu_data_d_in  in  DATA_W  input word
out_valid  out  1  output word present
out_ready  in  1  consumer accepts the output word
alu_data_d_out  out  DATA_W  permuted word
cnt_clr  in  1  synchronous clear of xfer_count
xfer_count  out  CNT_W  number of completed output transfers; wraps

Behaviour:
- Accept: in_valid & in_ready. Fire: out_valid & out_ready.
- Permutation is computed combinationally at accept time. Mode and rot are sampled with the data.
- Mode 0: out = in.
- Mode 1: out group g = in group NGRP-1-g.
- Mode 2: out bit b = in bit DATA_W-1-b.
- Mode 3: out group g = in group (g - (in_rot mod NGRP)) mod NGRP. Rot 0 equals pass.
- Storage: main register M, which drives the outputs, and skid register S.
- State EMPTY: out_valid=0, in_ready=1.
  - Accept -> ONE, M loads.
- State ONE: out_valid=1, in_ready=1.
  - Accept & fire -> ONE, M loads the new word.
  - Accept & !fire -> FULL, S loads.
  - !Accept & fire -> EMPTY.
  - Otherwise hold.
- State FULL: out_valid=1, in_ready=0.
  - Fire -> ONE, M<=S.
  - Otherwise hold.
- Latency: accepted in cycle N, visible on alu_data_d_out with out_valid in cycle N+1 when empty.
- Throughput: one word per cycle while out_ready=1.
- in_ready is a register output. It has no combinational path from out_ready.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- While out_valid=1 and out_ready=0, alu_data_d_out and out_valid hold stable.
- Counter: xfer_count += 1 on each fire, modulo 2^CNT_W.
  - cnt_clr sets it to 0.
  - cnt_clr and fire in the same cycle give 0; clear wins.
- Reset (rst_n=0 at a clock edge): state EMPTY, out_valid=0, alu_data_d_out=0, S=0, xfer_count=0.
  - in_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Reset mid-operation discards all buffered words. No output appears for them afterwards.
- in_valid while in_ready=0 is ignored. The source must hold the word.
- X on inputs while in_valid=0 must not propagate to state.

Test Plan:
- DATA_W=8, GROUP_W=4, mode 1, in 0xA5, out_ready=1 -> out 0x5A with out_valid one cycle after accept; xfer_count=1.
- DATA_W=8, mode 2, in 0x1E -> 0x78; mode 0, in 0x3C -> 0x3C; back-to-back words on consecutive cycles -> outputs on consecutive cycles, in_ready stays 1.
- DATA_W=16, GROUP_W=4, mode 3:
  - rot=1, in 0x1234 -> 0x2341.
  - rot=3 -> 0x4123.
  - rot=0 -> 0x1234.
- Backpressure, DATA_W=8:
  - Hold out_ready=0 and offer 0x11, 0x22, 0x33 in mode 0 -> 0x11 and 0x22 accepted; in_ready=0 the cycle after the second accept; 0x33 held by the source.
  - Raise out_ready -> out 0x11, 0x22, 0x33 in order, each stable until its fire.
- Counter: set CNT_W=4 and perform 17 fires -> xfer_count=1 (wrap). Assert cnt_clr in the same cycle as a fire -> 0.
- Reset while FULL, holding 0xAA and 0xBB -> after release out_valid=0, alu_data_d_out=0, in_ready=1, xfer_count=0; 0xAA and 0xBB never appear.
